// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: state encoding, default frame parameters
package uart_pkg;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;
    localparam int OVERSAMPLE  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    // Tick counter must hold both OVERSAMPLE-1 and SB_TICK-1.
    function automatic int tick_cnt_width(input int sb_tick);
        return ($clog2(sb_tick) < 4) ? 4 : $clog2(sb_tick);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampling UART receiver with framing-error detection
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            busy
);

    localparam int SW = tick_cnt_width(SB_TICK);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] START_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] DATA_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] STOP_LAST  = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    logic rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    uart_state_t     state, state_next;
    logic [SW-1:0]   s_cnt, s_cnt_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] shreg, shreg_next;
    logic [DBIT-1:0] dout_next;
    logic            frame_err_next;
    logic            done_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n            <= '0;
            shreg        <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            state        <= state_next;
            s_cnt        <= s_cnt_next;
            n            <= n_next;
            shreg        <= shreg_next;
            dout         <= dout_next;
            frame_err    <= frame_err_next;
            rx_done_tick <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        s_cnt_next     = s_cnt;
        n_next         = n;
        shreg_next     = shreg;
        dout_next      = dout;
        frame_err_next = frame_err;
        done_next      = 1'b0;

        case (state)
            // Start edge is taken without waiting for a tick, so the tick in
            // this cycle is deliberately not counted.
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_cnt_next = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt == START_LAST) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_cnt_next = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_cnt_next = s_cnt + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt == DATA_LAST) begin
                        s_cnt_next = '0;
                        shreg_next = {rx_s, shreg[DBIT-1:1]};
                        if (n == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n + NW'(1);
                        end
                    end else begin
                        s_cnt_next = s_cnt + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt == STOP_LAST) begin
                        dout_next      = shreg;
                        frame_err_next = ~rx_s;
                        done_next      = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        s_cnt_next = s_cnt + SW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       s_tick;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
    logic       busy;

    logic       tick_en;
    int         tick_div;
    int         pulse_cnt;
    int         exp_pulses;
    int         n_cmp;
    int         n_err;
    logic [7:0] q_dout[$];
    logic       q_ferr[$];

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        s_tick   = 1'b0;
        tick_div = 0;
        forever begin
            @(negedge clk);
            tick_div = (tick_div == 3) ? 0 : tick_div + 1;
            s_tick   = tick_en && (tick_div == 3);
        end
    end

    initial begin
        pulse_cnt = 0;
        forever begin
            @(negedge clk);
            if (rx_done_tick === 1'b1) begin
                pulse_cnt++;
                q_dout.push_back(dout);
                q_ferr.push_back(frame_err);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic send_bit(input logic b, input int nclk);
        rx = b;
        repeat (nclk) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) send_bit(data[i], BIT_CLK);
        // A low stop bit is cut short so the line is high again before the
        // receiver's follow-on start check, keeping that check unambiguous.
        send_bit(stop_bit, stop_bit ? BIT_CLK : 40);
        rx = 1'b1;
    endtask

    task automatic expect_frame(input string name, input logic [7:0] exp_d, input logic exp_fe);
        logic [7:0] d;
        logic       fe;
        n_cmp++;
        if (q_dout.size() == 0) begin
            n_err++;
            $display("FAIL %s_present: got no rx_done_tick, required one frame", name);
        end else begin
            d  = q_dout.pop_front();
            fe = q_ferr.pop_front();
            if (d !== exp_d) begin
                n_err++;
                $display("FAIL %s_dout: got %h required %h", name, d, exp_d);
            end
            n_cmp++;
            if (fe !== exp_fe) begin
                n_err++;
                $display("FAIL %s_frame_err: got %b required %b", name, fe, exp_fe);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx      = 1'b1;
        tick_en = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (dout !== 8'h00)        begin n_err++; $display("FAIL reset_dout: got %h required 00", dout); end
        n_cmp++; if (frame_err !== 1'b0)    begin n_err++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
        n_cmp++; if (rx_done_tick !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", rx_done_tick); end
    endtask

    task automatic test_good_frame();
        send_frame(8'hA5, 1'b1);
        repeat (60) @(negedge clk);
        exp_pulses++;
        n_cmp++;
        if (pulse_cnt !== exp_pulses) begin n_err++; $display("FAIL good_pulses: got %0d required %0d", pulse_cnt, exp_pulses); end
        expect_frame("good", 8'hA5, 1'b0);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL good_idle: busy got %b required 0", busy); end
    endtask

    task automatic test_glitch();
        send_bit(1'b0, 5);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy: got %b required 1", busy); end
        send_bit(1'b0, 7);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL glitch_idle: busy got %b required 0", busy); end
        n_cmp++; if (pulse_cnt !== exp_pulses) begin n_err++; $display("FAIL glitch_pulses: got %0d required %0d", pulse_cnt, exp_pulses); end
        n_cmp++; if (dout !== 8'hA5)         begin n_err++; $display("FAIL glitch_dout: got %h required a5", dout); end
    endtask

    task automatic test_frame_error();
        send_frame(8'h3C, 1'b0);
        repeat (60) @(negedge clk);
        exp_pulses++;
        n_cmp++;
        if (pulse_cnt !== exp_pulses) begin n_err++; $display("FAIL ferr_pulses: got %0d required %0d", pulse_cnt, exp_pulses); end
        expect_frame("ferr", 8'h3C, 1'b1);
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_held: got %b required 1", frame_err); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (60) @(negedge clk);
        exp_pulses += 2;
        n_cmp++;
        if (pulse_cnt !== exp_pulses) begin n_err++; $display("FAIL b2b_pulses: got %0d required %0d", pulse_cnt, exp_pulses); end
        expect_frame("b2b_first", 8'h00, 1'b0);
        expect_frame("b2b_second", 8'hFF, 1'b0);
        n_cmp++; if (dout !== 8'hFF) begin n_err++; $display("FAIL b2b_held: got %h required ff", dout); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h55;
        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) send_bit(d[i], BIT_CLK);
        send_bit(d[4], 20);
        reset_n = 1'b0;
        rx      = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL midrst_busy: got %b required 0", busy); end
        n_cmp++; if (dout !== 8'h00)        begin n_err++; $display("FAIL midrst_dout: got %h required 00", dout); end
        n_cmp++; if (rx_done_tick !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b required 0", rx_done_tick); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        n_cmp++; if (pulse_cnt !== exp_pulses) begin n_err++; $display("FAIL midrst_pulses: got %0d required %0d", pulse_cnt, exp_pulses); end
        send_frame(8'h81, 1'b1);
        repeat (60) @(negedge clk);
        exp_pulses++;
        n_cmp++;
        if (pulse_cnt !== exp_pulses) begin n_err++; $display("FAIL after_rst_pulses: got %0d required %0d", pulse_cnt, exp_pulses); end
        expect_frame("after_rst", 8'h81, 1'b0);
    endtask

    task automatic test_tick_stall();
        logic [7:0] d;
        d = 8'h6B;
        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 3; i++) send_bit(d[i], BIT_CLK);
        send_bit(d[3], 32);
        tick_en = 1'b0;
        send_bit(d[3], 100);
        n_cmp++; if (busy !== 1'b1)            begin n_err++; $display("FAIL stall_busy: got %b required 1", busy); end
        n_cmp++; if (pulse_cnt !== exp_pulses) begin n_err++; $display("FAIL stall_pulses: got %0d required %0d", pulse_cnt, exp_pulses); end
        tick_en = 1'b1;
        send_bit(d[3], 32);
        for (int i = 4; i < 8; i++) send_bit(d[i], BIT_CLK);
        send_bit(1'b1, BIT_CLK);
        repeat (60) @(negedge clk);
        exp_pulses++;
        n_cmp++;
        if (pulse_cnt !== exp_pulses) begin n_err++; $display("FAIL resume_pulses: got %0d required %0d", pulse_cnt, exp_pulses); end
        expect_frame("resume", 8'h6B, 1'b0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        exp_pulses = 0;
        reset_n    = 1'b0;
        rx         = 1'b1;
        tick_en    = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_tick_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
